// File: rtl/udlx_mem_defs.sv
// Shared definitions for the MEM stage: access-FSM state encoding and timeout counter width.
package udlx_mem_defs;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   localparam int TO_CNT_W = 16;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory req/ack sequencer: state, bus registers and (with MEM_TIMEOUT_EN) the abort counter.
module mem_access_fsm
   import udlx_mem_defs::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_ADDR_WIDTH = 20,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       wr_en,
   input  logic [DATA_ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       ack,
   output mem_state_e                 state,
   output logic                       done,
   output logic                       dmem_req,
   output logic                       dmem_wr_en,
   output logic [DATA_ADDR_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0]      dmem_wr_data,
   output logic                       mem_error
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_CNT_W)) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 1..65535");
   end

`ifdef MEM_TIMEOUT_EN
   localparam logic [TO_CNT_W-1:0] LAST_WAIT = TO_CNT_W'(TIMEOUT_CYCLES - 1);
   logic [TO_CNT_W-1:0] wait_cnt_q;
`else
   assign mem_error = 1'b0;
`endif

   // ack is only meaningful while an access is outstanding
   assign done = (state == ST_WAIT) && ack;

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         dmem_req     <= 1'b0;
         dmem_wr_en   <= 1'b0;
         dmem_addr    <= '0;
         dmem_wr_data <= '0;
`ifdef MEM_TIMEOUT_EN
         wait_cnt_q   <= '0;
         mem_error    <= 1'b0;
`endif
      end else begin
`ifdef MEM_TIMEOUT_EN
         mem_error <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state        <= ST_WAIT;
                  dmem_req     <= 1'b1;
                  dmem_wr_en   <= wr_en;
                  dmem_addr    <= addr;
                  dmem_wr_data <= wr_data;
`ifdef MEM_TIMEOUT_EN
                  wait_cnt_q   <= '0;
`endif
               end
            end
            ST_WAIT: begin
               if (ack) begin
                  state    <= ST_IDLE;
                  dmem_req <= 1'b0;
               end
`ifdef MEM_TIMEOUT_EN
               else if (wait_cnt_q == LAST_WAIT) begin
                  state     <= ST_IDLE;
                  dmem_req  <= 1'b0;
                  mem_error <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: pass-through for ALU ops, req/ack data-memory access for loads/stores.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage
   import udlx_mem_defs::*;
#(
   parameter int PC_WIDTH          = 20,
   parameter int DATA_WIDTH        = 32,
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int REG_ADDR_WIDTH    = 5,
   parameter int DATA_ADDR_WIDTH   = 20,
   parameter int TIMEOUT_CYCLES    = 255
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         mem_data_rd_en_in,
   input  logic                         mem_data_wr_en_in,
   input  logic [DATA_WIDTH-1:0]        mem_data_in,
   input  logic [DATA_WIDTH-1:0]        alu_data_in,
   input  logic [DATA_WIDTH-1:0]        hi_data_in,
   input  logic [REG_ADDR_WIDTH-1:0]    reg_a_wr_addr_in,
   input  logic [REG_ADDR_WIDTH-1:0]    reg_b_wr_addr_in,
   input  logic                         reg_a_wr_en_in,
   input  logic                         reg_b_wr_en_in,
   input  logic                         write_back_mux_sel_in,
   input  logic                         select_new_pc_in,
   input  logic [PC_WIDTH-1:0]          new_pc_in,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
   output logic                         dmem_req_out,
   output logic                         dmem_wr_en_out,
   output logic [DATA_ADDR_WIDTH-1:0]   dmem_addr_out,
   output logic [DATA_WIDTH-1:0]        dmem_wr_data_out,
   input  logic                         dmem_ack_in,
   input  logic [DATA_WIDTH-1:0]        dmem_rd_data_in,
   output logic                         stall_out,
   output logic [DATA_WIDTH-1:0]        wb_data_out,
   output logic [DATA_WIDTH-1:0]        hi_data_out,
   output logic [REG_ADDR_WIDTH-1:0]    reg_a_wr_addr_out,
   output logic [REG_ADDR_WIDTH-1:0]    reg_b_wr_addr_out,
   output logic                         reg_a_wr_en_out,
   output logic                         reg_b_wr_en_out,
   output logic                         select_new_pc_out,
   output logic [PC_WIDTH-1:0]          new_pc_out,
   output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
   output logic                         mem_error_out
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]        hi;
      logic [REG_ADDR_WIDTH-1:0]    a_addr;
      logic [REG_ADDR_WIDTH-1:0]    b_addr;
      logic                         a_en;
      logic                         b_en;
      logic                         sel_pc;
      logic [PC_WIDTH-1:0]          new_pc;
      logic [INSTRUCTION_WIDTH-1:0] instr;
   } side_t;

   mem_state_e            state;
   logic                  op;
   logic                  done;
   side_t                 in_side, hold_side, next_side, out_side;
   logic [DATA_WIDTH-1:0] hold_alu, next_wb, wb_q;
   logic                  hold_mux;

   // a store wins when both enables are raised
   assign op = mem_data_rd_en_in | mem_data_wr_en_in;

   assign in_side = '{hi: hi_data_in, a_addr: reg_a_wr_addr_in, b_addr: reg_b_wr_addr_in,
                      a_en: reg_a_wr_en_in, b_en: reg_b_wr_en_in, sel_pc: select_new_pc_in,
                      new_pc: new_pc_in, instr: instruction_in};

   mem_access_fsm #(
      .DATA_WIDTH      (DATA_WIDTH),
      .DATA_ADDR_WIDTH (DATA_ADDR_WIDTH),
      .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
   ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (op),
      .wr_en        (mem_data_wr_en_in),
      .addr         (alu_data_in[DATA_ADDR_WIDTH-1:0]),
      .wr_data      (mem_data_in),
      .ack          (dmem_ack_in),
      .state        (state),
      .done         (done),
      .dmem_req     (dmem_req_out),
      .dmem_wr_en   (dmem_wr_en_out),
      .dmem_addr    (dmem_addr_out),
      .dmem_wr_data (dmem_wr_data_out),
      .mem_error    (mem_error_out)
   );

   assign stall_out = (state == ST_IDLE) ? op : !dmem_ack_in;

   // NOTE: the hold register is pure datapath, only read after it has been loaded, so it takes no reset.
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && op) begin
         hold_side <= in_side;
         hold_alu  <= alu_data_in;
         hold_mux  <= write_back_mux_sel_in;
      end
   end

   // NOTE: defaults first so every path assigns every signal and no latch is inferred.
   always_comb begin
      next_side = '0;
      next_wb   = '0;
      if (state == ST_IDLE) begin
         if (!op) begin
            next_side = in_side;
            next_wb   = alu_data_in;
         end
      end else if (done) begin
         next_side = hold_side;
         next_wb   = hold_mux ? dmem_rd_data_in : hold_alu;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_side <= '0;
         wb_q     <= '0;
      end else begin
         out_side <= next_side;
         wb_q     <= next_wb;
      end
   end

   assign wb_data_out       = wb_q;
   assign hi_data_out       = out_side.hi;
   assign reg_a_wr_addr_out = out_side.a_addr;
   assign reg_b_wr_addr_out = out_side.b_addr;
   assign reg_a_wr_en_out   = out_side.a_en;
   assign reg_b_wr_en_out   = out_side.b_en;
   assign select_new_pc_out = out_side.sel_pc;
   assign new_pc_out        = out_side.new_pc;
   assign instruction_out   = out_side.instr;

endmodule
